bus_control_sequencer: RTL and testbench



---
 rtl/bus_control_sequencer.sv | 130 +++++++++++++
 tb/tb_bus_control_sequencer.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/bus_control_sequencer.sv
// bus_control_sequencer: multi-cycle fetch/decode/execute control FSM for a single-bus CPU datapath
module bus_control_sequencer (
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  output logic [15:0] r_out,
  output logic [15:0] r_in,
  output logic        hi_out,
  output logic        lo_out,
  output logic        zhi_out,
  output logic        zlo_out,
  output logic        pc_out,
  output logic        mdr_out,
  output logic        c_sign_out,
  output logic        pc_in,
  output logic        ir_in,
  output logic        mar_in,
  output logic        mdr_in,
  output logic        y_in,
  output logic        z_in,
  output logic        hi_in,
  output logic        lo_in,
  output logic        inc_pc,
  output logic        mem_read,
  output logic [4:0]  alu_op,
  output logic        halted
);
  typedef enum logic [3:0] {IDLE, T0, T1, T2, T3, T4, T5, T6, HALT} state_t;
  state_t state, nextState, endState;
  logic [4:0] opcode;
  logic [3:0] ra, rb, rc;
  logic isAlu, isAddi, isMulDiv, isMfhi, isMflo, isHalt, isArith;
  assign opcode   = ir[31:27];
  assign ra       = ir[26:23];
  assign rb       = ir[22:19];
  assign rc       = ir[18:15];
  assign isAlu    = opcode >= 5'd3 && opcode <= 5'd11;
  assign isAddi   = opcode == 5'd12;
  assign isMulDiv = opcode == 5'd15 || opcode == 5'd16;
  assign isMfhi   = opcode == 5'd23;
  assign isMflo   = opcode == 5'd24;
  assign isHalt   = opcode == 5'd27;
  assign isArith  = isAlu || isAddi || isMulDiv;
  assign endState = run ? T0 : IDLE;
  always_ff @(posedge clock)
    if (reset) state <= IDLE;
    else state <= nextState;
  always_comb begin
    r_out = '0;
    r_in = '0;
    hi_out = 1'b0;
    lo_out = 1'b0;
    zhi_out = 1'b0;
    zlo_out = 1'b0;
    pc_out = 1'b0;
    mdr_out = 1'b0;
    c_sign_out = 1'b0;
    pc_in = 1'b0;
    ir_in = 1'b0;
    mar_in = 1'b0;
    mdr_in = 1'b0;
    y_in = 1'b0;
    z_in = 1'b0;
    hi_in = 1'b0;
    lo_in = 1'b0;
    inc_pc = 1'b0;
    mem_read = 1'b0;
    alu_op = '0;
    halted = 1'b0;
    nextState = state;
    case (state)
      IDLE: nextState = run ? T0 : IDLE;
      T0: begin
        pc_out = 1'b1;
        mar_in = 1'b1;
        inc_pc = 1'b1;
        z_in = 1'b1;
        nextState = T1;
      end
      T1: begin
        mem_read = 1'b1;
        zlo_out = mem_ready;
        pc_in = mem_ready;
        mdr_in = mem_ready;
        nextState = mem_ready ? T2 : T1;
      end
      T2: begin
        mdr_out = 1'b1;
        ir_in = 1'b1;
        nextState = T3;
      end
      T3: begin
        if (isArith) begin
          r_out[rb] = 1'b1;
          y_in = 1'b1;
          nextState = T4;
        end else if (isHalt) begin
          nextState = HALT;
        end else begin
          hi_out = isMfhi;
          lo_out = isMflo;
          r_in[ra] = isMfhi || isMflo;
          nextState = endState;
        end
      end
      T4: begin
        r_out[rc] = !isAddi;
        c_sign_out = isAddi;
        alu_op = isAddi ? 5'd3 : opcode;
        z_in = 1'b1;
        nextState = T5;
      end
      T5: begin
        zlo_out = 1'b1;
        lo_in = isMulDiv;
        r_in[ra] = !isMulDiv;
        nextState = isMulDiv ? T6 : endState;
      end
      T6: begin
        zhi_out = 1'b1;
        hi_in = 1'b1;
        nextState = endState;
      end
      HALT: halted = 1'b1;
      default: nextState = IDLE;
    endcase
  end
endmodule

// File: tb/tb_bus_control_sequencer.sv
// tb_bus_control_sequencer: directed per-cycle expectations queued by stimulus, checked by an independent monitor
module tb_bus_control_sequencer;
  typedef struct packed {
    logic [15:0] rOut;
    logic [15:0] rIn;
    logic hiOut, loOut, zhiOut, zloOut, pcOut, mdrOut, cSignOut;
    logic pcIn, irIn, marIn, mdrIn, yIn, zIn, hiIn, loIn, incPc, memRead;
    logic [4:0] aluOp;
    logic halted;
  } outs_t;
  logic clk = 1'b0, reset, run, mem_ready;
  logic [31:0] ir;
  logic [15:0] r_out, r_in;
  logic hi_out, lo_out, zhi_out, zlo_out, pc_out, mdr_out, c_sign_out;
  logic pc_in, ir_in, mar_in, mdr_in, y_in, z_in, hi_in, lo_in, inc_pc, mem_read, halted;
  logic [4:0] alu_op;
  outs_t act;
  outs_t expQ[$];
  string nameQ[$];
  int total = 0, bad = 0;
  bit started = 0;
  bus_control_sequencer dut (
    .clock(clk), .reset(reset), .run(run), .ir(ir), .mem_ready(mem_ready),
    .r_out(r_out), .r_in(r_in), .hi_out(hi_out), .lo_out(lo_out), .zhi_out(zhi_out),
    .zlo_out(zlo_out), .pc_out(pc_out), .mdr_out(mdr_out), .c_sign_out(c_sign_out),
    .pc_in(pc_in), .ir_in(ir_in), .mar_in(mar_in), .mdr_in(mdr_in), .y_in(y_in),
    .z_in(z_in), .hi_in(hi_in), .lo_in(lo_in), .inc_pc(inc_pc), .mem_read(mem_read),
    .alu_op(alu_op), .halted(halted)
  );
  always #5 clk = ~clk;
  assign act = {r_out, r_in, hi_out, lo_out, zhi_out, zlo_out, pc_out, mdr_out, c_sign_out,
                pc_in, ir_in, mar_in, mdr_in, y_in, z_in, hi_in, lo_in, inc_pc, mem_read,
                alu_op, halted};
  always @(negedge clk) begin
    outs_t e;
    string n;
    if (started) begin
      total++;
      if (!$onehot0({r_out, hi_out, lo_out, zhi_out, zlo_out, pc_out, mdr_out, c_sign_out}) || !$onehot0(r_in)) begin
        bad++;
        $display("FAIL onehot got bus=%h r_in=%h want zero-or-one-hot", {r_out, hi_out, lo_out, zhi_out, zlo_out, pc_out, mdr_out, c_sign_out}, r_in);
      end
    end
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      n = nameQ.pop_front();
      total++;
      if (act !== e) begin
        bad++;
        $display("FAIL %s got=%h want=%h", n, act, e);
      end
    end
  end
  function automatic logic [31:0] mkIr(input logic [4:0] op, input logic [3:0] a, b, c);
    mkIr = {op, a, b, c, 15'd0};
  endfunction
  task automatic cyc(input outs_t e, input string n);
    expQ.push_back(e);
    nameQ.push_back(n);
    @(posedge clk);
    #1;
  endtask
  task automatic fetch(input string n);
    outs_t e;
    mem_ready = 1'b1;
    e = '0; e.pcOut = 1; e.marIn = 1; e.incPc = 1; e.zIn = 1;
    cyc(e, {n, "_t0"});
    e = '0; e.memRead = 1; e.zloOut = 1; e.pcIn = 1; e.mdrIn = 1;
    cyc(e, {n, "_t1"});
    e = '0; e.mdrOut = 1; e.irIn = 1;
    cyc(e, {n, "_t2"});
  endtask
  initial begin
    #100000;
    bad++;
    $display("FAIL watchdog got=timeout want=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
  initial begin
    outs_t e;
    reset = 1; run = 0; mem_ready = 0; ir = '0;
    @(posedge clk); #1;
    started = 1;
    cyc('0, "reset1");
    cyc('0, "reset2");
    reset = 0;
    cyc('0, "idle_run0");
    // add R3,R1,R2 zero wait, run held high so the next fetch follows directly
    ir = mkIr(5'd3, 4'd3, 4'd1, 4'd2);
    run = 1;
    cyc('0, "add_idle");
    fetch("add");
    e = '0; e.rOut = 16'h0002; e.yIn = 1; cyc(e, "add_t3");
    e = '0; e.rOut = 16'h0004; e.aluOp = 5'd3; e.zIn = 1; cyc(e, "add_t4");
    e = '0; e.zloOut = 1; e.rIn = 16'h0008; cyc(e, "add_t5");
    // nop with three memory wait cycles
    ir = mkIr(5'd26, 4'd0, 4'd0, 4'd0);
    e = '0; e.pcOut = 1; e.marIn = 1; e.incPc = 1; e.zIn = 1; cyc(e, "wait_t0");
    mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      e = '0; e.memRead = 1; cyc(e, "wait_t1_stall");
    end
    mem_ready = 1;
    e = '0; e.memRead = 1; e.zloOut = 1; e.pcIn = 1; e.mdrIn = 1; cyc(e, "wait_t1_ready");
    e = '0; e.mdrOut = 1; e.irIn = 1; cyc(e, "wait_t2");
    cyc('0, "nop_t3");
    // mul R4,R5
    ir = mkIr(5'd15, 4'd0, 4'd4, 4'd5);
    fetch("mul");
    e = '0; e.rOut = 16'h0010; e.yIn = 1; cyc(e, "mul_t3");
    e = '0; e.rOut = 16'h0020; e.aluOp = 5'd15; e.zIn = 1; cyc(e, "mul_t4");
    e = '0; e.zloOut = 1; e.loIn = 1; cyc(e, "mul_t5");
    e = '0; e.zhiOut = 1; e.hiIn = 1; cyc(e, "mul_t6");
    // mfhi R7, dropping run so the sequencer parks in IDLE afterwards
    ir = mkIr(5'd23, 4'd7, 4'd0, 4'd0);
    fetch("mfhi");
    run = 0;
    e = '0; e.hiOut = 1; e.rIn = 16'h0080; cyc(e, "mfhi_t3");
    cyc('0, "idle_after_mfhi");
    cyc('0, "idle_hold");
    // illegal opcode behaves as nop
    ir = mkIr(5'd31, 4'd9, 4'd9, 4'd9);
    run = 1;
    cyc('0, "ill_idle");
    fetch("ill");
    run = 0;
    cyc('0, "ill_t3");
    cyc('0, "ill_idle_after");
    // addi R6,R2 with reset during T4
    ir = mkIr(5'd12, 4'd6, 4'd2, 4'd0);
    run = 1;
    cyc('0, "addi_idle");
    fetch("addi");
    e = '0; e.rOut = 16'h0004; e.yIn = 1; cyc(e, "addi_t3");
    reset = 1;
    e = '0; e.cSignOut = 1; e.aluOp = 5'd3; e.zIn = 1; cyc(e, "addi_t4");
    reset = 0;
    cyc('0, "addi_after_reset");
    fetch("addi2");
    e = '0; e.rOut = 16'h0004; e.yIn = 1; cyc(e, "addi2_t3");
    e = '0; e.cSignOut = 1; e.aluOp = 5'd3; e.zIn = 1; cyc(e, "addi2_t4");
    e = '0; e.zloOut = 1; e.rIn = 16'h0040; cyc(e, "addi2_t5");
    // halt with run high, then reset out of HALT
    ir = mkIr(5'd27, 4'd0, 4'd0, 4'd0);
    fetch("halt");
    cyc('0, "halt_t3");
    e = '0; e.halted = 1;
    for (int i = 0; i < 20; i++) cyc(e, "halt_hold");
    reset = 1;
    cyc(e, "halt_reset_edge");
    reset = 0; run = 0;
    cyc('0, "halt_released");
    cyc('0, "halt_idle");
    for (int i = 0; i < 10 && expQ.size() > 0; i++) @(posedge clk);
    if (expQ.size() > 0) begin
      bad++;
      $display("FAIL drain got=%0d want=0", expQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
